// File: rtl/uart_sched_pkg.sv
// Shared constants and types for the Uart transmit scheduler: default MMIO addresses,
// drain FSM states, round-robin owner and status byte bit positions.
package uart_sched_pkg;

    localparam logic [15:0] TX_ADDR_DEFAULT     = 16'hf001;
    localparam logic [15:0] STATUS_ADDR_DEFAULT = 16'hf002;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    // Which requester wins the next two-way tie.
    typedef enum logic {
        RR_CPU = 1'b0,
        RR_DBG = 1'b1
    } rr_owner_t;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read port. Push while full and pop
// while empty are ignored, so callers may gate loosely without corrupting state.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Merges CPU MMIO writes and a debug byte stream into one FIFO with round-robin push
// arbitration, and drains the FIFO into the Uart over its req/done handshake.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [15:0] TX_ADDR     = TX_ADDR_DEFAULT,
    parameter logic [15:0] STATUS_ADDR = STATUS_ADDR_DEFAULT,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [15:0]    cpu_addr,
    input  logic [7:0]     cpu_data,
    input  logic           cpu_req,
    output logic           cpu_done,
    output logic [7:0]     cpu_rdata,
    input  logic [7:0]     dbg_data,
    input  logic           dbg_valid,
    output logic           dbg_ready,
    output logic [15:0]    uart_addr,
    output logic [7:0]     uart_data,
    output logic           uart_req,
    input  logic           uart_done,
    output logic [CW-1:0]  fifo_count,
    output drain_state_t   drain_state
);

    // Handshakes: the debug port transfers on a cycle where dbg_valid & dbg_ready; dbg_ready
    // never looks at dbg_valid. CPU and Uart sides hold their req until the matching done.
    logic         cpu_done_q, cpu_done_d;
    logic [7:0]   cpu_rdata_q, cpu_rdata_d;
    rr_owner_t    rr_q, rr_d;
    drain_state_t state_q;
    logic         uart_req_q;

    logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [7:0]   push_data;
    logic         acc_open, cpu_wr_elig, status_rd, dbg_elig, grant_cpu, grant_dbg;
    logic [7:0]   status;

    always_comb begin
        acc_open    = cpu_req & ~cpu_done_q;
        cpu_wr_elig = acc_open & (cpu_addr == TX_ADDR) & ~fifo_full;
        status_rd   = acc_open & (cpu_addr == STATUS_ADDR);
        dbg_elig    = dbg_valid & ~fifo_full;
        grant_cpu   = cpu_wr_elig & (~dbg_elig | (rr_q == RR_CPU));
        grant_dbg   = dbg_elig & (~cpu_wr_elig | (rr_q == RR_DBG));
        fifo_push   = grant_cpu | grant_dbg;
        push_data   = grant_cpu ? cpu_data : dbg_data;
        dbg_ready   = ~fifo_full & (~cpu_wr_elig | (rr_q == RR_DBG));
        fifo_pop    = (state_q == DRAIN_REQ) & uart_done;

        status              = '0;
        status[STAT_EMPTY]  = fifo_empty;
        status[STAT_FULL]   = fifo_full;
        status[STAT_BUSY]   = (state_q == DRAIN_REQ);

        cpu_done_d  = grant_cpu | status_rd;
        cpu_rdata_d = status_rd ? status : 8'h00;
        rr_d        = rr_q;
        if (grant_cpu) rr_d = RR_DBG;
        if (grant_dbg) rr_d = RR_CPU;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= 8'h00;
            rr_q        <= RR_CPU;
        end else begin
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            rr_q        <= rr_d;
        end
    end

    // Drain FSM: a new request can only start from IDLE, so after a pop there is always
    // at least one cycle with uart_req low.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= DRAIN_IDLE;
            uart_req_q <= 1'b0;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    if (!fifo_empty) begin
                        state_q    <= DRAIN_REQ;
                        uart_req_q <= 1'b1;
                    end
                end
                DRAIN_REQ: begin
                    if (uart_done) begin
                        state_q    <= DRAIN_IDLE;
                        uart_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= DRAIN_IDLE;
                    uart_req_q <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i (push_data),
        .pop_i   (fifo_pop),
        .head_o  (uart_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cpu_done    = cpu_done_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign uart_req    = uart_req_q;
    assign uart_addr   = TX_ADDR;
    assign drain_state = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler (DEPTH=4) with a queue-based reference model
// of the shared FIFO, a simple Uart responder and a byte-order scoreboard.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int          DEPTH  = 4;
    localparam int          CW     = $clog2(DEPTH) + 1;
    localparam logic [15:0] TX     = 16'hf001;
    localparam logic [15:0] STATUS = 16'hf002;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [15:0]    cpu_addr = '0;
    logic [7:0]     cpu_data = '0;
    logic           cpu_req = 1'b0;
    logic           cpu_done;
    logic [7:0]     cpu_rdata;
    logic [7:0]     dbg_data = '0;
    logic           dbg_valid = 1'b0;
    logic           dbg_ready;
    logic [15:0]    uart_addr;
    logic [7:0]     uart_data;
    logic           uart_req;
    logic           uart_done = 1'b0;
    logic [CW-1:0]  fifo_count;
    drain_state_t   drain_state;

    uart_tx_scheduler #(
        .DEPTH       (DEPTH),
        .TX_ADDR     (TX),
        .STATUS_ADDR (STATUS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_req     (cpu_req),
        .cpu_done    (cpu_done),
        .cpu_rdata   (cpu_rdata),
        .dbg_data    (dbg_data),
        .dbg_valid   (dbg_valid),
        .dbg_ready   (dbg_ready),
        .uart_addr   (uart_addr),
        .uart_data   (uart_data),
        .uart_req    (uart_req),
        .uart_done   (uart_done),
        .fifo_count  (fifo_count),
        .drain_state (drain_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    // The FIFO is a queue of expected bytes; occupancy is tracked separately because the
    // scoreboard removes bytes mid-cycle while the model's count changes on the edge.
    logic [7:0] exp_q[$];
    int         m_count = 0;
    bit         m_rr_dbg = 1'b0;
    bit         m_done = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    bit         m_offer = 1'b0;

    bit m_full, m_empty, m_open, m_cw, m_st, m_dv, m_gc, m_gd, m_pop;

    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            m_count  = 0;
            m_rr_dbg = 1'b0;
            m_done   = 1'b0;
            m_rdata  = 8'h00;
            m_offer  = 1'b0;
        end else begin
            m_full  = (m_count == DEPTH);
            m_empty = (m_count == 0);
            m_open  = cpu_req && !m_done;
            m_cw    = m_open && (cpu_addr == TX) && !m_full;
            m_st    = m_open && (cpu_addr == STATUS);
            m_dv    = dbg_valid && !m_full;
            m_gc    = m_cw && (!m_dv || !m_rr_dbg);
            m_gd    = m_dv && (!m_cw || m_rr_dbg);
            m_pop   = m_offer && uart_done;
            m_rdata = m_st ? {5'b0, m_offer, m_full, m_empty} : 8'h00;
            m_done  = m_gc || m_st;
            if (m_gc) begin
                exp_q.push_back(cpu_data);
                m_rr_dbg = 1'b1;
            end
            if (m_gd) begin
                exp_q.push_back(dbg_data);
                m_rr_dbg = 1'b0;
            end
            m_count = m_count + ((m_gc || m_gd) ? 1 : 0) - (m_pop ? 1 : 0);
            if (!m_offer) m_offer = !m_empty;
            else if (uart_done) m_offer = 1'b0;
        end
    end

    // ---------------- cycle checker ----------------
    bit exp_rdy;
    always @(negedge clock) begin
        if (chk_en) begin
            check("cpu_done", 32'(cpu_done), 32'(m_done));
            if (m_done) check("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata));
            check("uart_req", 32'(uart_req), 32'(m_offer));
            check("fifo_count", 32'(fifo_count), 32'(m_count));
            check("uart_addr", 32'(uart_addr), 32'(TX));
            exp_rdy = (m_count != DEPTH) &&
                      !(cpu_req && !m_done && cpu_addr == TX && !m_rr_dbg);
            check("dbg_ready", 32'(dbg_ready), 32'(exp_rdy));
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [7:0] sb_byte;
    always @(negedge clock) begin
        if (chk_en && !reset && uart_req && uart_done) begin
            if (exp_q.size() == 0) begin
                timeout_fail("uart_unexpected_byte");
            end else begin
                sb_byte = exp_q.pop_front();
                check("uart_data", 32'(uart_data), 32'(sb_byte));
            end
        end
    end

    // ---------------- Uart responder ----------------
    bit uart_hold = 1'b1;
    int uart_max  = 0;
    int wait_cnt  = 0;
    always @(posedge clock) begin
        #2;
        if (uart_done) begin
            uart_done = 1'b0;
        end else if (uart_hold || reset) begin
            wait_cnt = 0;
        end else if (uart_req) begin
            if (wait_cnt == 0) begin
                uart_done = 1'b1;
                wait_cnt  = $urandom_range(0, uart_max);
            end else begin
                wait_cnt--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cpu_access(input logic [15:0] addr, input logic [7:0] data,
                              output logic [7:0] rdata);
        int n;
        cpu_addr = addr;
        cpu_data = data;
        cpu_req  = 1'b1;
        rdata    = 8'h00;
        if (addr == TX || addr == STATUS) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!cpu_done && n < 5000);
            if (!cpu_done) timeout_fail("cpu_done_wait");
            rdata = cpu_rdata;
        end else begin
            repeat (3) tick();
        end
        cpu_req = 1'b0;
    endtask

    task automatic dbg_send(input logic [7:0] data);
        int n;
        bit rdy;
        dbg_data  = data;
        dbg_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            rdy = dbg_ready;
            tick();
            n++;
        end while (!rdy && n < 5000);
        if (!rdy) timeout_fail("dbg_ready_wait");
        dbg_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((m_count != 0 || m_offer) && n < 5000) begin
            tick();
            n++;
        end
        if (m_count != 0 || m_offer) timeout_fail("drain_wait");
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] rd;
    logic [15:0] raddr;
    int r;

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clock);
        check("reset_cpu_done", 32'(cpu_done), 32'd0);
        check("reset_uart_req", 32'(uart_req), 32'd0);
        check("reset_fifo_count", 32'(fifo_count), 32'd0);
        tick();

        // Status read with the FIFO empty and the drain idle.
        cpu_access(STATUS, 8'h00, rd);
        check("status_empty_idle", 32'(rd), 32'h01);

        // Single write, Uart takes a few cycles.
        uart_hold = 1'b0;
        uart_max  = 4;
        cpu_access(TX, 8'h55, rd);
        wait_drain();

        // Five back-to-back writes against a stalled Uart; the fifth must stall.
        uart_hold = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) cpu_access(TX, 8'h10 + 8'(i), rd);
            end
            begin
                repeat (20) tick();
                uart_hold = 1'b0;
            end
        join
        wait_drain();

        // Full FIFO, drain busy: status shows busy and full.
        uart_hold = 1'b1;
        for (int i = 0; i < 4; i++) cpu_access(TX, 8'ha0 + 8'(i), rd);
        cpu_access(STATUS, 8'h00, rd);
        check("status_full_busy", 32'(rd), 32'h06);

        // Push attempt in the very cycle the Uart completes: refused once, then accepted.
        uart_max = 0;
        fork
            cpu_access(TX, 8'hb5, rd);
            uart_hold = 1'b0;
        join
        wait_drain();

        // CPU and debug offered together four times.
        uart_max = 2;
        for (int i = 0; i < 4; i++) begin
            fork
                cpu_access(TX, 8'hc0 + 8'(i), rd);
                dbg_send(8'hd0 + 8'(i));
            join
        end
        wait_drain();

        // Randomized mix of writes, status reads, foreign addresses and debug bytes.
        uart_max = 6;
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) tick();
                    r = $urandom_range(0, 9);
                    if (r < 6) raddr = TX;
                    else if (r < 8) raddr = STATUS;
                    else raddr = 16'h0100 + 16'($urandom_range(0, 255));
                    cpu_access(raddr, 8'($urandom), rd);
                end
            end
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) tick();
                    dbg_send(8'($urandom));
                end
            end
        join
        wait_drain();

        // Reset in the middle of a Uart request with three bytes queued.
        uart_hold = 1'b1;
        for (int i = 0; i < 3; i++) cpu_access(TX, 8'he0 + 8'(i), rd);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_uart_req", 32'(uart_req), 32'd0);
        check("rst_mid_fifo_count", 32'(fifo_count), 32'd0);
        uart_hold = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
